// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - UART byte stream to instruction-memory word writes
// Holds the CPU in reset while a length-prefixed big-endian program image is loaded.
module prog_loader #(
    parameter int ADDR_WIDTH     = 14,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [7:0]            rx_byte,
    input  logic                  rx_valid,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [31:0]           wr_data,
    output logic                  cpu_hold,
    output logic                  done,
    output logic                  error,
    output logic [ADDR_WIDTH:0]   word_count
);

    localparam int          IDLE_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [31:0] CAPACITY = 32'd1 << ADDR_WIDTH;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_HI,
        S_LEN_LO,
        S_DATA,
        S_DONE,
        S_ERROR
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [15:0]           r_len;
    logic [23:0]           r_asm;
    logic [1:0]            r_byte_idx;
    logic [IDLE_W-1:0]     r_idle;
    logic                  r_wr_en;
    logic [31:0]           r_wr_data;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [ADDR_WIDTH:0]   r_word_count;
    logic                  r_cpu_hold;
    logic                  r_done;
    logic                  r_error;

    logic [15:0]           w_len_full;
    logic                  w_timeout;
    logic                  w_last_word;
    logic                  w_cpu_hold_next;
    logic                  w_done_next;
    logic                  w_error_next;

    assign w_len_full  = {r_len[15:8], rx_byte};
    assign w_timeout   = !rx_valid && ((32'(r_idle) + 32'd1) >= 32'(TIMEOUT_CYCLES));
    assign w_last_word = (32'(r_word_count) + 32'd1) == {16'd0, r_len};

    // State and status flags; flags are derived from the next state so they stay registered.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_cpu_hold <= 1'b0;
            r_done     <= 1'b0;
            r_error    <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_cpu_hold <= w_cpu_hold_next;
            r_done     <= w_done_next;
            r_error    <= w_error_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_LEN_HI: begin
                if (rx_valid) w_state_next = S_LEN_LO;
            end
            S_LEN_LO: begin
                if (rx_valid) begin
                    if (w_len_full == 16'd0)                  w_state_next = S_DONE;
                    else if ({16'd0, w_len_full} > CAPACITY) w_state_next = S_ERROR;
                    else                                      w_state_next = S_DATA;
                end else if (w_timeout) begin
                    w_state_next = S_ERROR;
                end
            end
            S_DATA: begin
                if (r_wr_en && w_last_word) w_state_next = S_DONE;
                else if (w_timeout)         w_state_next = S_ERROR;
            end
            default: ;
        endcase
        if (start) w_state_next = S_LEN_HI;
    end

    always_comb begin
        w_cpu_hold_next = 1'b0;
        w_done_next     = 1'b0;
        w_error_next    = 1'b0;
        case (w_state_next)
            S_LEN_HI, S_LEN_LO, S_DATA: w_cpu_hold_next = 1'b1;
            S_DONE:                     w_done_next     = 1'b1;
            S_ERROR: begin
                w_cpu_hold_next = 1'b1;
                w_error_next    = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_len        <= '0;
            r_asm        <= '0;
            r_byte_idx   <= '0;
            r_idle       <= '0;
            r_wr_en      <= 1'b0;
            r_wr_data    <= '0;
            r_addr       <= '0;
            r_word_count <= '0;
        end else if (start) begin
            r_byte_idx   <= '0;
            r_idle       <= '0;
            r_wr_en      <= 1'b0;
            r_addr       <= '0;
            r_word_count <= '0;
        end else begin
            r_wr_en <= 1'b0;
            case (r_state)
                S_LEN_HI: begin
                    if (rx_valid) begin
                        r_len[15:8] <= rx_byte;
                        r_idle      <= '0;
                    end
                end
                S_LEN_LO: begin
                    if (rx_valid) begin
                        r_len[7:0] <= rx_byte;
                        r_idle     <= '0;
                    end else begin
                        r_idle <= r_idle + IDLE_W'(1);
                    end
                end
                S_DATA: begin
                    if (rx_valid) begin
                        r_idle     <= '0;
                        r_asm      <= {r_asm[15:0], rx_byte};
                        r_byte_idx <= r_byte_idx + 2'd1;
                        if (r_byte_idx == 2'd3) begin
                            r_wr_data <= {r_asm, rx_byte};
                            r_wr_en   <= 1'b1;
                        end
                    end else begin
                        r_idle <= r_idle + IDLE_W'(1);
                    end
                    // Write completes at the end of the strobe; hold the address on the final word so it cannot wrap.
                    if (r_wr_en) begin
                        r_word_count <= r_word_count + 1'b1;
                        if (!w_last_word) r_addr <= r_addr + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign wr_en      = r_wr_en;
    assign wr_addr    = r_addr;
    assign wr_data    = r_wr_data;
    assign cpu_hold   = r_cpu_hold;
    assign done       = r_done;
    assign error      = r_error;
    assign word_count = r_word_count;

endmodule

// File: doc/prog_loader.md
# prog_loader

Programming-mode loader that turns a UART byte stream into 32-bit word writes to the instruction memory read by the instruction-fetch stage. It sits directly upstream of instruction fetch: it fills the program ROM port the fetch stage indexes with PC[15:2], and it holds the CPU in reset while loading.

## Interface
- ADDR_WIDTH, 14, word-address width of instruction memory; capacity 2^ADDR_WIDTH words.
- TIMEOUT_CYCLES, 1000000, idle clock cycles allowed between bytes once a transfer has started.

Ports:
- clock  in  1  system clock; all state changes on posedge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- start  in  1  one-cycle pulse; begins or restarts a load.
- rx_byte  in  8  received byte; valid only when rx_valid is high.
- rx_valid  in  1  one-cycle strobe per received byte.
- wr_en  out  1  one-cycle instruction-memory write strobe.
- wr_addr  out  ADDR_WIDTH  word address of the write; same word indexing as PC[15:2].
- wr_data  out  32  instruction word to write.
- cpu_hold  out  1  high while loading or after an error; feeds CPU reset.
- done  out  1  high after a successful load, until the next start or reset.
- error  out  1  high after a failed load, until the next start or reset.
- word_count  out  ADDR_WIDTH+1  number of words written in the current load.

## Operation
- Frame format: 2-byte word count N, sent big-endian, followed by N×4 bytes. Each word is sent big-endian: the first byte goes to wr_data[31:24].
- States: IDLE, LEN_HI, LEN_LO, DATA, DONE, ERROR.
- IDLE, DONE, ERROR:
  - rx_valid is ignored.
  - start → LEN_HI. Clear done, error, word_count, the address counter and the byte index. Set cpu_hold=1.
- LEN_HI: rx_valid → N[15:8] = rx_byte; go to LEN_LO.
- LEN_LO: rx_valid → N[7:0] = rx_byte, then:
  - N==0 → DONE.
  - N > 2^ADDR_WIDTH → ERROR.
  - otherwise → DATA.
- DATA:
  - Each rx_valid shifts the byte into a 24-bit assembly register and increments a 2-bit byte index.
  - On the 4th byte, the full word is registered into wr_data and wr_en is asserted.
  - The address counter increments when the write completes.
  - When the written count reaches N → DONE.
- Timeout:
  - In LEN_LO and DATA, an idle counter resets on every rx_valid.
  - Reaching TIMEOUT_CYCLES → ERROR.
  - LEN_HI has no timeout; it waits for the host indefinitely.
- cpu_hold:
  - 1 in LEN_HI, LEN_LO, DATA and ERROR.
  - 0 in IDLE and DONE.
  - The CPU never runs a partially loaded program.
- start in any state aborts and restarts at LEN_HI. Words already written stay in memory but are overwritten by the new load.
- start and rx_valid in the same cycle: start wins; the byte is dropped.

## Timing
- Reset values: state IDLE; wr_en 0, wr_addr 0, wr_data 0, cpu_hold 0, done 0, error 0, word_count 0.
- Outputs are registered, with no combinational input-to-output paths.
- Write latency: wr_en is high for exactly the one cycle after the edge that accepted a word's 4th byte. wr_addr and wr_data are stable in that cycle. wr_addr for word k is k (0-based).
- word_count increments on the edge that ends the wr_en cycle.
- Back-to-back bytes on consecutive cycles are supported. A byte accepted during a wr_en cycle belongs to the next word and is not lost.
- Last word: done rises and cpu_hold falls on the edge that ends the final wr_en cycle.
- Boundary cases:
  - N = 2^ADDR_WIDTH is accepted; the final wr_addr is all-ones, and the counter does not wrap before DONE.
  - N = 2^ADDR_WIDTH+1 → ERROR, with no writes.
- Error timing: error rises on the edge where the idle counter reaches TIMEOUT_CYCLES, measured from the last accepted byte.
- Reset asserted mid-load: wr_en drops immediately, with no write completed after reset. cpu_hold falls to 0 immediately.

## Test plan
- Basic load. Stimulus: start, then bytes 00 02 | 3C 01 00 10 | 00 00 00 0C. Required: two wr_en pulses, at (addr 0, 0x3C010010) and (addr 1, 0x0000000C). Then done=1, cpu_hold=0, word_count=2.
- Zero length. Stimulus: start, then 00 00. Required: no wr_en; done=1 one cycle after the second byte.
- Oversize length. Stimulus: start, then 40 01 (N=16385 with ADDR_WIDTH=14). Required: error=1, cpu_hold=1, no wr_en.
- Timeout. Stimulus: TIMEOUT_CYCLES=16; start, 00 01, AA BB, then silence. Required: error=1 exactly 16 cycles after the BB byte; no wr_en.
- Restart and collision. Stimulus: start, 00 02, 11 22 33 44, then start together with rx_valid=0x55, then 00 01 DE AD BE EF. Required: the first write is (0, 0x11223344); the 0x55 byte is dropped; the final write is (0, 0xDEADBEEF); done=1, word_count=1.
- Async reset. Stimulus: assert reset between bytes 2 and 3 of a word. Required: all outputs take their reset values immediately (before the next clock edge); a subsequent start loads cleanly.
